keypad_scan_frontend: RTL

//  Upstream stage of the note-memory game. Scans a 4-row x 3-col key matrix, synchronises and

---
 rtl/keypad_scan_frontend_if.sv | 27 ++
 rtl/keypad_scan_frontend.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_frontend_if.sv
// Key-matrix pins and debounced key status between the scan frontend (master) and the game (slave).
interface keypad_scan_frontend_if;
  logic [3:0] row_in;
  logic [2:0] col_out;
  logic [3:0] key_code;
  logic       key_press;
  logic       key_release;
  logic       key_held;

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_press,
    output key_release,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_press,
    input  key_release,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_frontend.sv
// 4x3 keypad scanner: column drive, row synchroniser, frame debounce and key press/release encoding.
// Optional auto-repeat of key_press while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_frontend #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_RATE     = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  keypad_scan_frontend_if.master kp
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int STAB_W = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST     = DIV_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_FULL    = STAB_W'(DEBOUNCE_FRAMES);
  localparam logic [3:0]        CODE_NONE    = 4'h0;
  localparam logic [3:0]        CODE_INVALID = 4'hF;

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("keypad_scan_frontend: SCAN_DIV must be at least 4");
  end
  if (DEBOUNCE_FRAMES < 1) begin : g_bad_debounce
    $error("keypad_scan_frontend: DEBOUNCE_FRAMES must be at least 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
    $error("keypad_scan_frontend: REPEAT_DELAY and REPEAT_RATE must be at least 1");
  end

  // One-hot state encoding doubles as the column drive pattern.
  typedef enum logic [2:0] {
    COL0 = 3'b001,
    COL1 = 3'b010,
    COL2 = 3'b100
  } scan_state_e;

  scan_state_e       scanState_q, scanState_d;
  logic [DIV_W-1:0]  divCnt_q, divCnt_d;
  logic [3:0]        rowMeta_q, rowSync_q;
  logic [11:0]       frameBits_q, frameBits_d, frameNow;
  logic [3:0]        frameCode;
  logic [3:0]        bitCount, bitCode;
  logic              sampleTick, frameEnd;

  logic [3:0]        cand_q, cand_d;
  logic [STAB_W-1:0] stabCnt_q, stabCnt_d;
  logic [3:0]        state_q, state_d;
  logic [3:0]        keyCode_q, keyCode_d;
  logic              keyPress_q, keyPress_d;
  logic              keyRelease_q, keyRelease_d;
  logic              keyHeld_q, keyHeld_d;
  logic              accept;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [RPT_W-1:0] RPT_DELAY_CNT = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RATE_CNT  = RPT_W'(REPEAT_RATE);

  logic [RPT_W-1:0] rptCnt_q, rptCnt_d, rptCntInc;
  logic             rptArmed_q, rptArmed_d;
  logic             rptFire;
`endif

  assign sampleTick = (divCnt_q == DIV_LAST);
  assign frameEnd   = sampleTick && (scanState_q == COL2);

  always_comb begin
    scanState_d = scanState_q;
    divCnt_d    = divCnt_q + 1'b1;
    if (sampleTick) begin
      divCnt_d = '0;
      case (scanState_q)
        COL0:    scanState_d = COL1;
        COL1:    scanState_d = COL2;
        default: scanState_d = COL0;
      endcase
    end
  end

  // Frame bit index is row*3+col; the live column is merged in so the frame is complete at COL2.
  always_comb begin
    frameNow = frameBits_q;
    for (int r = 0; r < 4; r++) begin
      case (scanState_q)
        COL0:    frameNow[r*3]     = rowSync_q[r];
        COL1:    frameNow[r*3 + 1] = rowSync_q[r];
        default: frameNow[r*3 + 2] = rowSync_q[r];
      endcase
    end
    frameBits_d = sampleTick ? frameNow : frameBits_q;
  end

  always_comb begin
    bitCount  = '0;
    bitCode   = '0;
    frameCode = CODE_NONE;
    for (int i = 0; i < 12; i++) begin
      if (frameNow[i]) begin
        bitCount = bitCount + 4'd1;
        bitCode  = 4'(i + 1);
      end
    end
    if (bitCount == 4'd1) begin
      frameCode = bitCode;
    end else if (bitCount != 4'd0) begin
      frameCode = CODE_INVALID;
    end
  end

  always_comb begin
    cand_d       = cand_q;
    stabCnt_d    = stabCnt_q;
    state_d      = state_q;
    keyCode_d    = keyCode_q;
    keyHeld_d    = keyHeld_q;
    keyPress_d   = 1'b0;
    keyRelease_d = 1'b0;
    accept       = 1'b0;

    if (frameEnd) begin
      if (frameCode == cand_q) begin
        if (stabCnt_q != STAB_FULL) begin
          stabCnt_d = stabCnt_q + 1'b1;
        end
      end else begin
        cand_d    = frameCode;
        stabCnt_d = STAB_W'(1);
      end
      accept = (stabCnt_d == STAB_FULL) && (cand_d != CODE_INVALID) && (cand_d != state_q);
    end

    // Key-to-key roll-over goes straight to the new code without a release pulse.
    if (accept) begin
      state_d = cand_d;
      if (cand_d == CODE_NONE) begin
        keyHeld_d    = 1'b0;
        keyRelease_d = 1'b1;
      end else begin
        keyCode_d  = cand_d;
        keyHeld_d  = 1'b1;
        keyPress_d = 1'b1;
      end
    end

`ifdef KEYPAD_REPEAT_EN
    rptCnt_d   = rptCnt_q;
    rptArmed_d = rptArmed_q;
    rptCntInc  = rptCnt_q + 1'b1;
    rptFire    = 1'b0;
    if (accept) begin
      rptCnt_d   = '0;
      rptArmed_d = 1'b0;
    end else if (frameEnd && (state_q != CODE_NONE)) begin
      rptCnt_d = rptCntInc;
      if ((!rptArmed_q && (rptCntInc == RPT_DELAY_CNT)) ||
          (rptArmed_q && (rptCntInc == RPT_RATE_CNT))) begin
        rptFire    = 1'b1;
        rptCnt_d   = '0;
        rptArmed_d = 1'b1;
      end
    end
    if (rptFire) begin
      keyPress_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      scanState_q  <= COL0;
      divCnt_q     <= '0;
      rowMeta_q    <= '0;
      rowSync_q    <= '0;
      frameBits_q  <= '0;
      cand_q       <= CODE_NONE;
      stabCnt_q    <= '0;
      state_q      <= CODE_NONE;
      keyCode_q    <= CODE_NONE;
      keyPress_q   <= 1'b0;
      keyRelease_q <= 1'b0;
      keyHeld_q    <= 1'b0;
    end else begin
      scanState_q  <= scanState_d;
      divCnt_q     <= divCnt_d;
      rowMeta_q    <= kp.row_in;
      rowSync_q    <= rowMeta_q;
      frameBits_q  <= frameBits_d;
      cand_q       <= cand_d;
      stabCnt_q    <= stabCnt_d;
      state_q      <= state_d;
      keyCode_q    <= keyCode_d;
      keyPress_q   <= keyPress_d;
      keyRelease_q <= keyRelease_d;
      keyHeld_q    <= keyHeld_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rptCnt_q   <= '0;
      rptArmed_q <= 1'b0;
    end else begin
      rptCnt_q   <= rptCnt_d;
      rptArmed_q <= rptArmed_d;
    end
  end
`endif

  assign kp.col_out     = scanState_q;
  assign kp.key_code    = keyCode_q;
  assign kp.key_press   = keyPress_q;
  assign kp.key_release = keyRelease_q;
  assign kp.key_held    = keyHeld_q;

endmodule
